// File: rtl/mandel_fb_pkg.sv
// Shared constants and width helper for the Mandelbrot frame buffer and its arbiter.
package mandel_fb_pkg;

  localparam int unsigned PixW       = 9;
  localparam int unsigned DefHActive = 32;
  localparam int unsigned DefVActive = 24;
  localparam int unsigned DefLanes   = 2;
  localparam int unsigned DefScale   = 20;

  // Bits needed to index n items; never less than one so single-entry ranges stay legal.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mandel_rr_arbiter.sv
// Round-robin grant over LANES requesters; the pointer moves one past the last granted lane.
module mandel_rr_arbiter
  import mandel_fb_pkg::*;
#(
  parameter int unsigned LANES = DefLanes
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] i_req,
  output logic [LANES-1:0] o_grant
);

  localparam int unsigned PtrW = addr_w(LANES);

  logic [PtrW-1:0] r_ptr, w_ptr_nxt, w_idx, w_jp;
  logic [31:0]     w_j;
  logic            w_found;

  // Grant is suppressed while reset is asserted so no transfer can slip through.
  always_comb begin
    o_grant = '0;
    w_idx   = r_ptr;
    w_found = 1'b0;
    w_j     = '0;
    w_jp    = '0;
    if (reset) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        w_j  = (32'(r_ptr) + i) % LANES;
        w_jp = PtrW'(w_j);
        if (!w_found && i_req[w_jp]) begin
          w_found       = 1'b1;
          o_grant[w_jp] = 1'b1;
          w_idx         = w_jp;
        end
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_found) begin
      w_ptr_nxt = (32'(w_idx) + 32'd1 >= LANES) ? '0 : w_idx + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_ptr <= '0;
    else        r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/mandel_frame_buffer.sv
// Multi-lane fractal frame buffer with upscaled display readout.
// Define FB_DOUBLE_BUFFER_EN for front/back banks swapped on frame_sync after a complete fill.
module mandel_frame_buffer
  import mandel_fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned PIX_W    = PixW,
  parameter int unsigned LANES    = DefLanes,
  parameter int unsigned SCALE_X  = DefScale,
  parameter int unsigned SCALE_Y  = DefScale,
  localparam int unsigned ADDR_W  = addr_w(H_ACTIVE * V_ACTIVE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*ADDR_W-1:0] in_addr,
  input  logic [LANES*PIX_W-1:0]  in_data,
  output logic [LANES-1:0]        in_ready,
  input  logic                    fill_start,
  output logic                    fill_done,
  output logic                    addr_err,
  input  logic                    frame_sync,
  input  logic                    line_sync,
  input  logic                    pix_en,
  output logic [PIX_W-1:0]        pix_data,
  output logic                    pix_valid
);

  localparam int unsigned Depth = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CntW  = addr_w(Depth + 1);
  localparam int unsigned SxW   = addr_w(SCALE_X);
  localparam int unsigned BxW   = addr_w(H_ACTIVE);
  localparam int unsigned SyW   = addr_w(SCALE_Y);
  localparam int unsigned ByW   = addr_w(V_ACTIVE);
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif
  localparam int unsigned MemAW = addr_w(NumBanks * Depth);

  logic [LANES-1:0]  w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [PIX_W-1:0]  w_data;
  logic              w_any, w_in_range, w_we, w_clr, w_col_en;
  logic [31:0]       w_wr_off, w_rd_off;
  logic [MemAW-1:0]  w_wr_idx, w_rd_idx;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_addr_err;
  logic [SxW-1:0]    r_sx, w_sx;
  logic [BxW-1:0]    r_bx, w_bx;
  logic [SyW-1:0]    r_sy, w_sy;
  logic [ByW-1:0]    r_by, w_by;
  logic [PIX_W-1:0]  r_pix_data;
  logic              r_pix_valid;
  logic [PIX_W-1:0]  r_mem [NumBanks*Depth];

  mandel_rr_arbiter #(
    .LANES (LANES)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (in_valid),
    .o_grant (w_grant)
  );

  assign in_ready = w_grant;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (w_grant[k]) begin
        w_addr = in_addr[k*ADDR_W +: ADDR_W];
        w_data = in_data[k*PIX_W +: PIX_W];
      end
    end
  end

  assign w_any      = |w_grant;
  assign w_in_range = ({1'b0, w_addr} < (ADDR_W + 1)'(Depth));
  assign w_we       = w_any & w_in_range;

`ifdef FB_DOUBLE_BUFFER_EN
  logic r_front, w_swap, w_front;
  // The swap is visible to this cycle's read and write so both see the new bank roles.
  assign w_swap   = frame_sync & fill_done;
  assign w_front  = r_front ^ w_swap;
  assign w_clr    = fill_start | w_swap;
  assign w_rd_off = w_front ? 32'(Depth) : 32'd0;
  assign w_wr_off = w_front ? 32'd0 : 32'(Depth);

  always_ff @(posedge clk) begin
    if (!reset) r_front <= 1'b0;
    else        r_front <= w_front;
  end
`else
  assign w_clr    = fill_start;
  assign w_rd_off = 32'd0;
  assign w_wr_off = 32'd0;
`endif

  assign w_wr_idx = MemAW'(w_wr_off + 32'(w_addr));
  assign w_rd_idx = frame_sync ? MemAW'(w_rd_off)
                               : MemAW'(w_rd_off + 32'(r_by) * H_ACTIVE + 32'(r_bx));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_clr) begin
      w_cnt_nxt = w_we ? CntW'(1) : '0;
    end else if (w_we && (r_cnt != CntW'(Depth))) begin
      w_cnt_nxt = r_cnt + CntW'(1);
    end
  end

  assign fill_done = (r_cnt == CntW'(Depth));
  assign addr_err  = r_addr_err;

  // A pix_en alongside frame_sync advances from the zeroed position; alongside line_sync it is
  // only a read.
  always_comb begin
    w_sx     = r_sx;
    w_bx     = r_bx;
    w_sy     = r_sy;
    w_by     = r_by;
    w_col_en = 1'b0;
    if (frame_sync) begin
      w_sx     = '0;
      w_bx     = '0;
      w_sy     = '0;
      w_by     = '0;
      w_col_en = pix_en;
    end else if (line_sync) begin
      w_sx = '0;
      w_bx = '0;
      if (r_sy == SyW'(SCALE_Y - 1)) begin
        w_sy = '0;
        w_by = (r_by == ByW'(V_ACTIVE - 1)) ? '0 : r_by + ByW'(1);
      end else begin
        w_sy = r_sy + SyW'(1);
      end
    end else begin
      w_col_en = pix_en;
    end
    if (w_col_en) begin
      if (w_sx == SxW'(SCALE_X - 1)) begin
        w_sx = '0;
        w_bx = (w_bx == BxW'(H_ACTIVE - 1)) ? '0 : w_bx + BxW'(1);
      end else begin
        w_sx = w_sx + SxW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_idx] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_addr_err  <= 1'b0;
      r_sx        <= '0;
      r_bx        <= '0;
      r_sy        <= '0;
      r_by        <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_addr_err  <= r_addr_err | (w_any & ~w_in_range);
      r_sx        <= w_sx;
      r_bx        <= w_bx;
      r_sy        <= w_sy;
      r_by        <= w_by;
      r_pix_valid <= pix_en;
      if (pix_en) r_pix_data <= r_mem[w_rd_idx];
    end
  end

  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_mandel_frame_buffer.sv
// Directed self-checking bench for mandel_frame_buffer at default geometry (32x24, 2 lanes, 20x20).
module tb_mandel_frame_buffer;

  localparam int unsigned AW    = 10;
  localparam int unsigned PW    = 9;
  localparam int unsigned Depth = 768;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      in_valid;
  logic [2*AW-1:0] in_addr;
  logic [2*PW-1:0] in_data;
  logic [1:0]      in_ready;
  logic            fill_start, fill_done, addr_err;
  logic            frame_sync, line_sync, pix_en;
  logic [PW-1:0]   pix_data;
  logic            pix_valid;

  logic [PW-1:0]   exp_mem [Depth];
  int              n_tests = 0;
  int              n_fail  = 0;

  mandel_frame_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fill_start (fill_start),
    .fill_done  (fill_done),
    .addr_err   (addr_err),
    .frame_sync (frame_sync),
    .line_sync  (line_sync),
    .pix_en     (pix_en),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [PW-1:0] pat(input int a);
    return PW'((a * 7 + 3) & 511);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-lane write held for one cycle; the lane is expected to be granted immediately.
  task automatic wr1(input int lane, input int addr, input logic [PW-1:0] data, input logic fs);
    in_valid             = 2'b00;
    in_valid[lane]       = 1'b1;
    in_addr[lane*AW +: AW] = addr[AW-1:0];
    in_data[lane*PW +: PW] = data;
    fill_start           = fs;
    #1;
    chk("ready_single", 32'(in_ready), 32'(1 << lane));
    tick();
    in_valid   = 2'b00;
    fill_start = 1'b0;
    if (addr < Depth) exp_mem[addr] = data;
  endtask

  task automatic pix(input logic fs, input logic ls, input logic [PW-1:0] exp);
    pix_en     = 1'b1;
    frame_sync = fs;
    line_sync  = ls;
    tick();
    pix_en     = 1'b0;
    frame_sync = 1'b0;
    line_sync  = 1'b0;
    chk("pix_data", 32'(pix_data), 32'(exp));
    chk("pix_valid", 32'(pix_valid), 32'd1);
  endtask

  task automatic fill_both();
    int a0 = 0;
    int a1 = 1;
    for (int t = 0; t < int'(Depth); t++) begin
      in_valid         = {a1 < int'(Depth), a0 < int'(Depth)};
      in_addr[AW-1:0]  = a0[AW-1:0];
      in_addr[2*AW-1:AW] = a1[AW-1:0];
      in_data[PW-1:0]  = pat(a0);
      in_data[2*PW-1:PW] = pat(a1);
      #1;
      chk("rr_grant", 32'(in_ready), (t % 2 == 0) ? 32'd1 : 32'd2);
      if (t == int'(Depth) - 1) chk("fill_done_pre", 32'(fill_done), 32'd0);
      tick();
      if (t % 2 == 0) begin
        exp_mem[a0] = pat(a0);
        a0 += 2;
      end else begin
        exp_mem[a1] = pat(a1);
        a1 += 2;
      end
    end
    in_valid = 2'b00;
    chk("fill_done_post", 32'(fill_done), 32'd1);
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 2'b11;
    in_addr    = '0;
    in_data    = '0;
    fill_start = 1'b0;
    frame_sync = 1'b0;
    line_sync  = 1'b0;
    pix_en     = 1'b1;
    #1;
    chk("reset_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("reset_fill_done", 32'(fill_done), 32'd0);
    chk("reset_addr_err", 32'(addr_err), 32'd0);
    chk("reset_pix_data", 32'(pix_data), 32'd0);
    chk("reset_pix_valid", 32'(pix_valid), 32'd0);
    in_valid = 2'b00;
    pix_en   = 1'b0;
    reset    = 1'b1;
    tick();

`ifdef FB_DOUBLE_BUFFER_EN
    for (int a = 0; a < int'(Depth); a++) wr1(0, a, 9'h007, 1'b0);
    chk("db_fill_a_done", 32'(fill_done), 32'd1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("db_swap_clears", 32'(fill_done), 32'd0);
    for (int a = 0; a < int'(Depth); a++) wr1(0, a, 9'h038, 1'b0);
    chk("db_fill_b_done", 32'(fill_done), 32'd1);
    pix(1'b0, 1'b0, 9'h007);
    pix(1'b1, 1'b0, 9'h038);
    chk("db_swap_clears_b", 32'(fill_done), 32'd0);
    pix(1'b1, 1'b0, 9'h038);
`else
    // Alternating two-lane fill of the whole frame.
    fill_both();

    // Lone lane 1 is granted at once; saturated count keeps fill_done high.
    wr1(1, 5, 9'h1FF, 1'b0);
    chk("fill_done_sat", 32'(fill_done), 32'd1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int x = 0; x < 120; x++) pix(1'b0, 1'b0, exp_mem[x / 20]);
    tick();
    chk("idle_pix_valid", 32'(pix_valid), 32'd0);
    chk("idle_pix_hold", 32'(pix_data), 32'(exp_mem[5]));

    // 45 lines: by=2, sy=5, so the next pixel reads raster address 64.
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    line_sync  = 1'b1;
    repeat (45) tick();
    line_sync  = 1'b0;
    pix(1'b0, 1'b0, exp_mem[64]);

    // frame_sync + pix_en reads address 0 while address 0 is rewritten: old data expected.
    pix_en          = 1'b1;
    frame_sync      = 1'b1;
    in_valid        = 2'b01;
    in_addr[AW-1:0] = '0;
    in_data[PW-1:0] = 9'h0F0;
    #1;
    chk("rdw_ready", 32'(in_ready), 32'd1);
    tick();
    pix_en     = 1'b0;
    frame_sync = 1'b0;
    in_valid   = 2'b00;
    chk("rdw_old_data", 32'(pix_data), 32'(exp_mem[0]));
    chk("fs_keeps_fill", 32'(fill_done), 32'd1);
    exp_mem[0] = 9'h0F0;

    line_sync = 1'b1;
    tick();
    line_sync = 1'b0;
    for (int x = 0; x < 20; x++) pix(1'b0, 1'b0, exp_mem[0]);
    pix(1'b0, 1'b1, exp_mem[1]);
    pix(1'b0, 1'b0, exp_mem[0]);

    // Fill accounting: coincident fill_start, dropped out-of-range write, sticky addr_err.
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("fill_start_clears", 32'(fill_done), 32'd0);
    wr1(0, 0, 9'h0AA, 1'b1);
    chk("coincident_not_done", 32'(fill_done), 32'd0);
    chk("addr_err_clear", 32'(addr_err), 32'd0);
    wr1(0, 768, 9'h155, 1'b0);
    chk("addr_err_set", 32'(addr_err), 32'd1);
    for (int a = 1; a < 767; a++) wr1(0, a, pat(a) ^ 9'h1AA, 1'b0);
    chk("count_767_not_done", 32'(fill_done), 32'd0);
    wr1(0, 767, 9'h033, 1'b0);
    chk("count_768_done", 32'(fill_done), 32'd1);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("refill_clears", 32'(fill_done), 32'd0);
    chk("addr_err_sticky", 32'(addr_err), 32'd1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    pix(1'b0, 1'b0, 9'h0AA);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
